// File: rtl/title_screen.sv
// Attract/title screen sequencer: colour-cycled logo, blinking start bar, fade-out,
// play hand-off and game-over hold, with registered title-layer RGB and mux select.
module title_screen #(
    parameter int         COLOR_PERIOD = 16,
    parameter int         BLINK_PERIOD = 32,
    parameter int         FADE_STEP    = 4,
    parameter int         HOLD_FRAMES  = 120,
    parameter logic [7:0] START_KEY    = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       is_galaga,
    input  logic [7:0] keycode,
    input  logic       game_over,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       title_active,
    output logic       game_start
);
    // state    | meaning
    // TITLE    | colour-cycled logo, blinking start bar, waiting for start key
    // FADE     | logo fading out one shift per FADE_STEP frames
    // PLAY     | game logic owns the screen, title layer black
    // GAMEOVER | red logo held for HOLD_FRAMES frames
    typedef enum logic [1:0] {S_TITLE, S_FADE, S_PLAY, S_GAMEOVER} state_t;

    localparam int CW = $clog2(COLOR_PERIOD + 1);
    localparam int BW = $clog2(BLINK_PERIOD + 1);
    localparam int FW = $clog2(FADE_STEP + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] COLOR_LAST = CW'(COLOR_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
    localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_STEP - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] color_cnt_q, color_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [FW-1:0] fade_cnt_q, fade_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    palette_q, palette_d;
    logic [2:0]    fade_shift_q, fade_shift_d;
    logic          blink_q, blink_d;
    logic          frame_meta_q, frame_sync_q, frame_prev_q;
    logic          key_hit_q, key_prev_q;
    logic [23:0]   rgb_q, rgb_d;
    logic          title_active_q, title_active_d;
    logic          game_start_q, game_start_d;
    logic          frame_tick, key_press;
    logic [1:0]    pal_idx;
    logic [23:0]   base;
    logic [2:0]    shift;
    logic          on_bar;

    assign frame_tick = frame_sync_q & ~frame_prev_q;
    assign key_press  = key_hit_q & ~key_prev_q;

    // Key flags reset high so a key held through reset shows no rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_prev_q <= 1'b0;
            key_hit_q    <= 1'b1;
            key_prev_q   <= 1'b1;
        end else begin
            frame_meta_q <= frame_clk;
            frame_sync_q <= frame_meta_q;
            frame_prev_q <= frame_sync_q;
            key_hit_q    <= (keycode == START_KEY);
            key_prev_q   <= key_hit_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_TITLE;
            color_cnt_q    <= '0;
            blink_cnt_q    <= '0;
            fade_cnt_q     <= '0;
            hold_cnt_q     <= '0;
            palette_q      <= '0;
            fade_shift_q   <= '0;
            blink_q        <= 1'b0;
            rgb_q          <= '0;
            title_active_q <= 1'b1;
            game_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            color_cnt_q    <= color_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            fade_cnt_q     <= fade_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            palette_q      <= palette_d;
            fade_shift_q   <= fade_shift_d;
            blink_q        <= blink_d;
            rgb_q          <= rgb_d;
            title_active_q <= title_active_d;
            game_start_q   <= game_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        color_cnt_d  = color_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        fade_cnt_d   = fade_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        palette_d    = palette_q;
        fade_shift_d = fade_shift_q;
        blink_d      = blink_q;
        case (state_q)
            S_TITLE: begin
                if (key_press) begin
                    state_d      = S_FADE;
                    fade_cnt_d   = '0;
                    fade_shift_d = '0;
                end else if (frame_tick) begin
                    if (color_cnt_q == COLOR_LAST) begin
                        color_cnt_d = '0;
                        palette_d   = palette_q + 2'd1;
                    end else begin
                        color_cnt_d = color_cnt_q + 1'b1;
                    end
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            S_FADE: begin
                if (frame_tick) begin
                    if (fade_cnt_q == FADE_LAST) begin
                        fade_cnt_d = '0;
                        if (fade_shift_q == 3'd7) state_d = S_PLAY;
                        else fade_shift_d = fade_shift_q + 3'd1;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (game_over) begin
                    state_d    = S_GAMEOVER;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                if (frame_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d      = S_TITLE;
                        hold_cnt_d   = '0;
                        color_cnt_d  = '0;
                        blink_cnt_d  = '0;
                        fade_cnt_d   = '0;
                        palette_d    = '0;
                        fade_shift_d = '0;
                        blink_d      = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        pal_idx = (state_q == S_GAMEOVER) ? 2'd1 : palette_q;
        case (pal_idx)
            2'd0:    base = 24'hFFFFFF;
            2'd1:    base = 24'hFF0000;
            2'd2:    base = 24'hFFFF00;
            default: base = 24'h00FFFF;
        endcase
        shift  = (state_q == S_FADE) ? fade_shift_q : 3'd0;
        on_bar = (state_q == S_TITLE) && blink_q &&
                 (DrawX >= 10'd272) && (DrawX <= 10'd368) &&
                 (DrawY >= 10'd256) && (DrawY <= 10'd259);
        rgb_d = 24'h000000;
        if (state_q != S_PLAY) begin
            if (is_galaga) rgb_d = {base[23:16] >> shift, base[15:8] >> shift, base[7:0] >> shift};
            else if (on_bar) rgb_d = 24'hFFFFFF;
        end
        title_active_d = (state_q != S_PLAY);
        game_start_d   = (state_q == S_FADE) && (state_d == S_PLAY);
    end

    assign Red          = rgb_q[23:16];
    assign Green        = rgb_q[15:8];
    assign Blue         = rgb_q[7:0];
    assign title_active = title_active_q;
    assign game_start   = game_start_q;
endmodule

// File: tb/tb_title_screen.sv
// Self-checking bench for title_screen: pixel expectations queued on drive and
// compared one Clk later, plus start-pulse and reset checks.
module tb_title_screen;
    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, is_galaga, game_over;
    logic [9:0] DrawX, DrawY;
    logic [7:0] keycode;
    logic [7:0] Red, Green, Blue;
    logic       title_active, game_start;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int gs_cnt = 0;
    int gs_cyc = 0;
    int ta_fall_cyc = 0;
    logic ta_prev = 1'b1;
    logic [24:0] exp_q[$];

    title_screen dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .is_galaga(is_galaga),
        .keycode(keycode), .game_over(game_over),
        .Red(Red), .Green(Green), .Blue(Blue),
        .title_active(title_active), .game_start(game_start)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (game_start) begin
            gs_cnt <= gs_cnt + 1;
            gs_cyc <= cyc;
        end
        if (ta_prev && !title_active) ta_fall_cyc <= cyc;
        ta_prev <= title_active;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] pal(int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFF0000;
            2:       return 24'hFFFF00;
            default: return 24'h00FFFF;
        endcase
    endfunction

    function automatic logic [23:0] fade(logic [23:0] c, int s);
        logic [7:0] r, g, b;
        r = c[23:16] >> s;
        g = c[15:8] >> s;
        b = c[7:0] >> s;
        return {r, g, b};
    endfunction

    task automatic cycles(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        cycles(4);
        frame_clk = 1'b0;
        cycles(4);
    endtask

    // Drive one pixel, queue its expected {title_active, RGB}, compare after the register.
    task automatic expect_px(string tag, int x, int y, logic gal, logic [24:0] exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        is_galaga = gal;
        exp_q.push_back(exp);
        cycles(1);
        chk(tag, {title_active, Red, Green, Blue}, exp_q.pop_front());
    endtask

    task automatic press_key();
        keycode = 8'h00;
        cycles(3);
        keycode = 8'h28;
        cycles(3);
    endtask

    task automatic run_fade(string tag);
        int base_cnt;
        base_cnt = gs_cnt;
        for (int k = 0; k < 32; k++) begin
            if (k % 4 == 0)
                expect_px($sformatf("%s_shift%0d", tag, k / 4), 100, 100, 1'b1,
                          {1'b1, fade(pal(0), k / 4)});
            if (k == 31) chk($sformatf("%s_gs_early", tag), gs_cnt - base_cnt, 0);
            frame();
        end
        chk($sformatf("%s_gs_once", tag), gs_cnt - base_cnt, 1);
        chk($sformatf("%s_ta_lag", tag), ta_fall_cyc - gs_cyc, 1);
        expect_px($sformatf("%s_play_logo", tag), 100, 100, 1'b1, 25'h0);
    endtask

    int bx[8] = '{271, 272, 368, 369, 300, 300, 300, 300};
    int by[8] = '{257, 257, 257, 257, 255, 256, 259, 260};
    int bon[8] = '{0, 1, 1, 0, 0, 1, 1, 0};

    initial begin
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        DrawX = '0;
        DrawY = '0;
        is_galaga = 1'b0;
        keycode = 8'h28;
        game_over = 1'b0;
        cycles(3);
        chk("rst_rgb", {Red, Green, Blue}, 24'h0);
        chk("rst_ta", title_active, 1);
        chk("rst_gs", game_start, 0);
        Reset_n = 1'b1;
        cycles(1);

        // Start key held since reset: title keeps cycling the palette and blinking.
        for (int f = 0; f <= 64; f++) begin
            expect_px($sformatf("logo_f%0d", f), 100, 100, 1'b1, {1'b1, pal((f / 16) % 4)});
            expect_px($sformatf("bar_f%0d", f), 300, 257, 1'b0,
                      {1'b1, ((f / 32) % 2 == 1) ? 24'hFFFFFF : 24'h0});
            expect_px($sformatf("below_bar_f%0d", f), 300, 260, 1'b0, {1'b1, 24'h0});
            if (f == 40)
                for (int i = 0; i < 8; i++)
                    expect_px($sformatf("bar_edge_%0d_%0d", bx[i], by[i]), bx[i], by[i], 1'b0,
                              {1'b1, (bon[i] == 1) ? 24'hFFFFFF : 24'h0});
            if (f < 64) frame();
        end

        press_key();
        run_fade("fade1");
        expect_px("play_bar", 300, 257, 1'b0, 25'h0);

        game_over = 1'b1;
        cycles(3);
        game_over = 1'b0;
        expect_px("go_logo", 100, 100, 1'b1, {1'b1, 24'hFF0000});
        expect_px("go_nobar", 300, 257, 1'b0, {1'b1, 24'h0});
        for (int h = 0; h < 120; h++) begin
            if (h == 119) expect_px("go_hold119", 100, 100, 1'b1, {1'b1, 24'hFF0000});
            frame();
        end
        expect_px("go_back_title", 100, 100, 1'b1, {1'b1, 24'hFFFFFF});
        repeat (4) frame();
        expect_px("title_key_held", 100, 100, 1'b1, {1'b1, 24'hFFFFFF});

        game_over = 1'b1;
        cycles(2);
        game_over = 1'b0;
        cycles(2);
        expect_px("go_ignored_title", 100, 100, 1'b1, {1'b1, 24'hFFFFFF});

        press_key();
        repeat (4) frame();
        expect_px("fade2_shift1", 100, 100, 1'b1, {1'b1, 24'h7F7F7F});
        repeat (2) frame();
        Reset_n = 1'b0;
        cycles(1);
        chk("midfade_rst_rgb", {Red, Green, Blue}, 24'h0);
        chk("midfade_rst_ta", title_active, 1);
        chk("midfade_rst_gs", game_start, 0);
        Reset_n = 1'b1;
        cycles(3);
        repeat (4) frame();
        expect_px("rst_key_held", 100, 100, 1'b1, {1'b1, 24'hFFFFFF});
        press_key();
        run_fade("fade3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
